// File: rtl/led_seq_pkg.sv
// Shared constants for the LED pattern sequencer: FSM states, mode codes, accumulator sizing.
package led_seq_pkg;

    localparam int ACC_W         = 26;
    localparam int LIMIT_DEFAULT = 50000000;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    typedef enum logic [2:0] {
        S_OFF,
        S_BLINK,
        S_SHIFT,
        S_BOUNCE_L,
        S_BOUNCE_R
    } state_t;

endpackage

// File: rtl/led_seq_tick.sv
// Fractional rate generator: adds step every cycle and emits a tick when the sum reaches LIMIT.
module led_seq_tick
    import led_seq_pkg::*;
#(
    parameter int LIMIT = LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] step,
    output logic       ovf,
    output logic       tick
);

    localparam logic [ACC_W:0] LIM = (ACC_W + 1)'(LIMIT);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] rem;
    logic             wrap;

    // One extra bit on the sum so acc + step can never lose a carry.
    assign sum  = {1'b0, acc} + (ACC_W + 1)'(step);
    assign wrap = (sum >= LIM);
    assign rem  = ACC_W'(sum - LIM);
    assign ovf  = wrap && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (wrap) begin
            acc  <= rem;
            tick <= 1'b1;
        end else begin
            acc  <= sum[ACC_W-1:0];
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer (off / blink / shift / bounce) paced by led_seq_tick.
// Define LEDSEQ_SW_SYNC_EN to pass SW through a 2-flop synchronizer.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int LIMIT = LIMIT_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [9:0] SW,
    output logic [7:0] LEDG,
    output logic       TICK
);

    logic [9:0] sw_s;

`ifdef LEDSEQ_SW_SYNC_EN
    logic [9:0] sw_meta;
    logic [9:0] sw_sync;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    assign sw_s = sw_sync;
`else
    assign sw_s = SW;
`endif

    logic [1:0] mode_sw;
    logic [1:0] mode_q;
    logic [7:0] step;
    logic       mode_chg;
    logic       ovf;
    state_t     state;
    state_t     state_d;
    logic [7:0] ledg_d;

    assign mode_sw  = sw_s[9:8];
    assign step     = sw_s[7:0];
    assign mode_chg = (mode_sw != mode_q);

    // A mode change clears the accumulator, which also discards a coincident tick.
    led_seq_tick #(
        .LIMIT(LIMIT)
    ) u_tick (
        .clk  (CLOCK_50),
        .rst  (RESET),
        .clear(mode_chg),
        .step (step),
        .ovf  (ovf),
        .tick (TICK)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state  <= S_OFF;
            mode_q <= MODE_OFF;
            LEDG   <= 8'h00;
        end else begin
            state  <= state_d;
            mode_q <= mode_sw;
            LEDG   <= ledg_d;
        end
    end

    always_comb begin
        state_d = state;
        ledg_d  = LEDG;
        if (mode_chg) begin
            case (mode_sw)
                MODE_OFF:    begin state_d = S_OFF;      ledg_d = 8'h00; end
                MODE_BLINK:  begin state_d = S_BLINK;    ledg_d = 8'hFF; end
                MODE_SHIFT:  begin state_d = S_SHIFT;    ledg_d = 8'h01; end
                default:     begin state_d = S_BOUNCE_L; ledg_d = 8'h01; end
            endcase
        end else if (ovf) begin
            // Pattern moves on the same edge that raises TICK.
            case (state)
                S_OFF:   ledg_d = 8'h00;
                S_BLINK: ledg_d = ~LEDG;
                S_SHIFT: ledg_d = {LEDG[6:0], LEDG[7]};
                S_BOUNCE_L: begin
                    if (LEDG[7]) begin
                        ledg_d  = 8'h40;
                        state_d = S_BOUNCE_R;
                    end else begin
                        ledg_d = {LEDG[6:0], 1'b0};
                    end
                end
                S_BOUNCE_R: begin
                    if (LEDG[0]) begin
                        ledg_d  = 8'h02;
                        state_d = S_BOUNCE_L;
                    end else begin
                        ledg_d = {1'b0, LEDG[7:1]};
                    end
                end
                default: begin
                    state_d = S_OFF;
                    ledg_d  = 8'h00;
                end
            endcase
        end
    end

endmodule
